// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from several requesters into one uart_tx, with
// per-message channel locking, frame-time pacing between strobes and a lock timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned CLOCKS_PER_BAUD = 104,
  parameter int unsigned FRAME_BITS      = 10,
  parameter int unsigned LOCK_TIMEOUT    = 120000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CHANNELS-1:0]   req_valid_i,
  input  logic [8*NUM_CHANNELS-1:0] req_data_i,
  input  logic [NUM_CHANNELS-1:0]   req_last_i,
  output logic [NUM_CHANNELS-1:0]   req_ready_o,
  output logic                      write_o,
  output logic [7:0]                data_o,
  output logic                      busy_o,
  output logic [2:0]                chan_o,
  output logic                      timeout_o
);

  localparam int unsigned FrameClks = FRAME_BITS * CLOCKS_PER_BAUD;
  localparam int unsigned PaceW     = (FrameClks > 1) ? $clog2(FrameClks) : 1;
  localparam int unsigned LockW     = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [PaceW-1:0] PaceLoad = PaceW'(FrameClks - 1);
  localparam logic [LockW-1:0] LockMax  = LockW'(LOCK_TIMEOUT);
  localparam logic [2:0]       LastCh   = 3'(NUM_CHANNELS - 1);
  localparam logic [3:0]       NumCh4   = 4'(NUM_CHANNELS);

  typedef enum logic [1:0] {StIdle, StStrobe, StPace} state_e;

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       chan_q, chan_d;
  logic             busy_q, busy_d;
  logic [2:0]       rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [2:0]       lock_ch_q, lock_ch_d;
  logic [PaceW-1:0] pace_q, pace_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;

  // Zero-extended copies so a 3-bit channel index is always in range.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;

  assign valid_pad = 8'(req_valid_i);
  assign last_pad  = 8'(req_last_i);
  assign data_pad  = 64'(req_data_i);

  function automatic logic [2:0] next_ch(input logic [2:0] ch);
    return (ch >= LastCh) ? 3'd0 : ch + 3'd1;
  endfunction

  logic       grant_vld;
  logic [2:0] grant_ch;
  logic [3:0] scan_idx;
  logic       lock_expire;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    scan_idx  = '0;
    if (state_q == StIdle) begin
      if (lock_q) begin
        grant_vld = valid_pad[lock_ch_q];
        grant_ch  = lock_ch_q;
      end else begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          scan_idx = {1'b0, rr_q} + 4'(i);
          if (scan_idx >= NumCh4) begin
            scan_idx = scan_idx - NumCh4;
          end
          if (!grant_vld && valid_pad[scan_idx[2:0]]) begin
            grant_vld = 1'b1;
            grant_ch  = scan_idx[2:0];
          end
        end
      end
    end
  end

  // Ready is gated by reset so the outputs read all-zero while rst_ni is low.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      req_ready_o[k] = rst_ni && grant_vld && (grant_ch == 3'(k));
    end
  end

  assign lock_expire = (state_q == StIdle) && lock_q && !valid_pad[lock_ch_q] &&
                       (lock_cnt_q == LockMax);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    chan_d     = chan_q;
    busy_d     = busy_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    pace_d     = pace_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          data_d     = data_pad[{grant_ch, 3'b000} +: 8];
          chan_d     = grant_ch;
          busy_d     = 1'b1;
          state_d    = StStrobe;
          lock_cnt_d = '0;
          if (last_pad[grant_ch]) begin
            lock_d = 1'b0;
            rr_d   = next_ch(grant_ch);
          end else begin
            lock_d    = 1'b1;
            lock_ch_d = grant_ch;
          end
        end else if (lock_expire) begin
          lock_d     = 1'b0;
          rr_d       = next_ch(lock_ch_q);
          lock_cnt_d = '0;
        end else if (lock_q) begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      StStrobe: begin
        pace_d  = PaceLoad;
        state_d = StPace;
      end
      StPace: begin
        if (pace_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          pace_d = pace_q - PaceW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      data_q     <= '0;
      chan_q     <= '0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      pace_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      pace_q     <= pace_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign write_o   = (state_q == StStrobe);
  assign data_o    = data_q;
  assign busy_o    = busy_q;
  assign chan_o    = chan_q;
  assign timeout_o = lock_expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single-byte grants plus
// hand-written round-robin, lock, timeout, mid-frame reset and random-traffic sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        write;
  logic [7:0]  data;
  logic        busy;
  logic [2:0]  chan;
  logic        timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .NUM_CHANNELS   (4),
    .CLOCKS_PER_BAUD(4),
    .FRAME_BITS     (10),
    .LOCK_TIMEOUT   (50)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .write_o    (write),
    .data_o     (data),
    .busy_o     (busy),
    .chan_o     (chan),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Waits from a strobe-cycle negedge until busy_o drops; returns the cycle count.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy !== 1'b0 && cycles < 200);
    check("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  // Invariants on every cycle: ready at most one-hot, silent while busy, strobe spacing.
  int cyc       = 0;
  int last_wr   = 0;
  bit have_wr   = 1'b0;
  int n_writes  = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      have_wr = 1'b0;
    end else begin
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (busy === 1'b1) check("ready_while_busy", 32'(req_ready), 32'd0);
      if (write === 1'b1) begin
        if (have_wr) check("write_spacing_ge41", 32'((cyc - last_wr) >= 41), 32'd1);
        last_wr = cyc;
        have_wr = 1'b1;
        n_writes++;
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] bytes;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_data;
    logic [2:0]  exp_ch;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cycles;
    int tk;
    int wr_seen;
    int wr_before;
    int st_cyc[5];
    logic [2:0] st_ch[5];
    int got;
    int c;

    // Sequential context carried from vector to vector: rr_ptr and lock are noted per row.
    vecs[0] = '{4'b0001, 4'b1111, 32'h44434241, 4'b0001, 8'h41, 3'd0};  // rr -> 1
    vecs[1] = '{4'b1111, 4'b1111, 32'h14131211, 4'b0010, 8'h12, 3'd1};  // rr -> 2
    vecs[2] = '{4'b0011, 4'b1111, 32'h24232221, 4'b0001, 8'h21, 3'd0};  // wrap, rr -> 1
    vecs[3] = '{4'b1100, 4'b1111, 32'h34333231, 4'b0100, 8'h33, 3'd2};  // rr -> 3
    vecs[4] = '{4'b0110, 4'b0000, 32'h54535251, 4'b0010, 8'h52, 3'd1};  // lock ch1
    vecs[5] = '{4'b1111, 4'b1111, 32'h64636261, 4'b0010, 8'h62, 3'd1};  // locked, rr -> 2
    vecs[6] = '{4'b1001, 4'b1111, 32'h74737271, 4'b1000, 8'h74, 3'd3};  // rr -> 0
    vecs[7] = '{4'b1010, 4'b1111, 32'h84838281, 4'b0010, 8'h82, 3'd1};  // rr -> 2
    vecs[8] = '{4'b0001, 4'b0001, 32'h94939291, 4'b0001, 8'h91, 3'd0};  // rr -> 1
    vecs[9] = '{4'b1000, 4'b1000, 32'hA4A3A2A1, 4'b1000, 8'hA4, 3'd3};  // rr -> 0

    // Reset with requests pending: every output must read zero.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    req_data  = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = vecs[i].bytes;
      @(negedge clk);
      check("vec_ready", 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      check("vec_write", 32'(write), 32'd1);
      check("vec_data", 32'(data), 32'(vecs[i].exp_data));
      check("vec_chan", 32'(chan), 32'(vecs[i].exp_ch));
      check("vec_busy", 32'(busy), 32'd1);
      wait_idle(cycles);
      check("vec_busy_len", 32'(cycles), 32'd41);
    end

    // Round-robin with all channels streaming single bytes; rr_ptr starts at 0.
    @(posedge clk); #1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hD3D2D1D0;
    got = 0;
    c   = 0;
    while (got < 5 && c < 400) begin
      @(negedge clk);
      c++;
      if (write === 1'b1) begin
        st_cyc[got] = c;
        st_ch[got]  = chan;
        got++;
      end
    end
    check("rr_count", 32'(got), 32'd5);
    check("rr_ch0", 32'(st_ch[0]), 32'd0);
    check("rr_ch1", 32'(st_ch[1]), 32'd1);
    check("rr_ch2", 32'(st_ch[2]), 32'd2);
    check("rr_ch3", 32'(st_ch[3]), 32'd3);
    check("rr_ch4", 32'(st_ch[4]), 32'd0);
    // Idle handshake cycle + strobe + 40 pacing cycles between consecutive strobes.
    for (int k = 1; k < 5; k++) check("rr_gap", 32'(st_cyc[k] - st_cyc[k-1]), 32'd42);
    req_valid = 4'b0000;
    wait_idle(cycles);

    // Lock: ch1 sends "AB" while ch2 waits; rr_ptr is 1 here.
    @(posedge clk); #1;
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    req_data  = 32'h00434100;
    @(negedge clk);
    check("lock_ready_a", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_data = 32'h00434200;
    req_last = 4'b0110;
    @(negedge clk);
    check("lock_data_a", 32'(data), 32'h41);
    wait_idle(cycles);
    check("lock_hold", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("lock_data_b", 32'(data), 32'h42);
    check("lock_chan_b", 32'(chan), 32'd1);
    wait_idle(cycles);
    check("lock_ready_c", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("lock_data_c", 32'(data), 32'h43);
    check("lock_chan_c", 32'(chan), 32'd2);
    wait_idle(cycles);

    // Timeout: ch3 leaves a message open, ch0 waits; rr_ptr is 3 here.
    @(posedge clk); #1;
    req_valid = 4'b1001;
    req_last  = 4'b0001;
    req_data  = 32'h5A000030;
    @(negedge clk);
    check("to_ready_3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("to_data_3", 32'(data), 32'h5A);
    wait_idle(cycles);
    tk = -1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      if (timeout === 1'b1) begin
        tk = k;
        break;
      end
    end
    check("to_cycle", 32'(tk), 32'd50);
    check("to_still_locked", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("to_pulse_width", 32'(timeout), 32'd0);
    check("to_ready_0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("to_data_0", 32'(data), 32'h30);
    check("to_chan_0", 32'(chan), 32'd0);
    wait_idle(cycles);

    // Reset at PACE cycle 10; rr_ptr is 1, so ch2 wins first.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    req_data  = 32'h00770000;
    @(negedge clk);
    check("mr_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("mr_data", 32'(data), 32'h77);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_write", 32'(write), 32'd0);
    check("mr_data0", 32'(data), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_chan", 32'(chan), 32'd0);
    check("mr_ready0", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    wr_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (write === 1'b1) wr_seen++;
    end
    check("mr_no_reissue", 32'(wr_seen), 32'd0);
    // Pre-reset rr_ptr was 3 (would pick ch3); after reset the scan starts at ch0.
    @(posedge clk); #1;
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    req_data  = 32'h99000088;
    @(negedge clk);
    check("mr_restart", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("mr_new_data", 32'(data), 32'h88);
    wait_idle(cycles);

    // Random traffic; the per-cycle invariants above do the checking.
    wr_before = n_writes;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom_range(0, 15));
      req_last  = 4'($urandom_range(0, 15));
      req_data  = $urandom;
    end
    req_valid = 4'b0000;
    check("rand_activity", 32'((n_writes - wr_before) >= 100), 32'd1);
    repeat (50) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
